pwm_decoder: RTL

PWM_DECODER -- requirements
Module: pwm_decoder

---
 rtl/pwm_decoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pwm_decoder.sv
// PWM duty/direction decoder: measures high time and period of a
// sign-magnitude PWM line and reports a 7-bit duty plus direction bit.
module pwm_decoder #(
  parameter int STEP_LOG2  = 7,
  parameter int PERIOD_TOL = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwm_in,
  input  logic       dir_in,
  output logic [7:0] pwm_val,
  output logic       valid,
  output logic       period_err,
  output logic       stuck_high
);

  localparam int NOM = 128 << STEP_LOG2;
  localparam int TMO = 2 * NOM;
  localparam int LO  = (NOM > PERIOD_TOL) ? NOM - PERIOD_TOL : 0;
  localparam int HI  = NOM + PERIOD_TOL;

  localparam logic [15:0] TMO_C  = 16'(TMO);
  localparam logic [16:0] LO_C   = 17'(LO);
  localparam logic [16:0] HI_C   = 17'(HI);
  localparam logic [16:0] HALF_C = 17'(1 << (STEP_LOG2 - 1));

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t state;

  logic pwm_meta;
  logic pwm_sync;
  logic pwm_dly;
  logic pwm_prev;
  logic dir_meta;
  logic dir_sync;
  logic dir_dly;

  logic [15:0] per_cnt;
  logic [15:0] high_cnt;
  logic [15:0] per_inc;
  logic [15:0] high_inc;

  logic        rise;
  logic        fall;
  logic        in_tol;
  logic        tmo;
  logic [16:0] rnd;
  logic [16:0] quo;
  logic [6:0]  duty;

  // Two-flop synchronizers, then one more stage for edge history
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_meta <= 1'b0;
      pwm_sync <= 1'b0;
      pwm_dly  <= 1'b0;
      pwm_prev <= 1'b0;
      dir_meta <= 1'b0;
      dir_sync <= 1'b0;
      dir_dly  <= 1'b0;
    end else begin
      pwm_meta <= pwm_in;
      pwm_sync <= pwm_meta;
      pwm_dly  <= pwm_sync;
      pwm_prev <= pwm_dly;
      dir_meta <= dir_in;
      dir_sync <= dir_meta;
      dir_dly  <= dir_sync;
    end
  end

  // Edge detect, saturating increments and period evaluation
  always_comb begin
    rise     = pwm_dly & ~pwm_prev;
    fall     = ~pwm_dly & pwm_prev;
    tmo      = (per_cnt == TMO_C);
    per_inc  = (per_cnt == 16'hFFFF) ? per_cnt : per_cnt + 16'd1;
    high_inc = (high_cnt == 16'hFFFF) ? high_cnt : high_cnt + 16'd1;
    in_tol   = ({1'b0, per_cnt} >= LO_C) && ({1'b0, per_cnt} <= HI_C);
    rnd      = {1'b0, high_cnt} + HALF_C;
    quo      = rnd >> STEP_LOG2;
    duty     = (quo > 17'd127) ? 7'd127 : quo[6:0];
  end

  // Measurement FSM with registered outputs. A restart loads the
  // counters with 1 so the edge cycle itself belongs to the new
  // interval and per_cnt equals the true period at the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SYNC;
      per_cnt    <= 16'd0;
      high_cnt   <= 16'd0;
      pwm_val    <= 8'h00;
      valid      <= 1'b0;
      period_err <= 1'b0;
      stuck_high <= 1'b0;
    end else begin
      valid      <= 1'b0;
      period_err <= 1'b0;
      if (fall) begin
        stuck_high <= 1'b0;
      end
      unique case (state)
        SYNC: begin
          if (rise) begin
            per_cnt  <= 16'd1;
            high_cnt <= 16'd1;
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (tmo) begin
            if (pwm_dly) begin
              stuck_high <= 1'b1;
              per_cnt    <= 16'd0;
              high_cnt   <= 16'd0;
              state      <= SYNC;
            end else begin
              valid    <= 1'b1;
              pwm_val  <= {dir_dly, 7'd0};
              per_cnt  <= 16'd1;
              high_cnt <= 16'd0;
              state    <= LOW;
            end
          end else begin
            per_cnt <= per_inc;
            if (pwm_dly) begin
              high_cnt <= high_inc;
            end
            if (fall) begin
              state <= LOW;
            end
          end
        end
        LOW: begin
          if (rise) begin
            if (in_tol) begin
              valid   <= 1'b1;
              pwm_val <= {dir_dly, duty};
            end else begin
              period_err <= 1'b1;
            end
            per_cnt  <= 16'd1;
            high_cnt <= 16'd1;
            state    <= HIGH;
          end else if (tmo) begin
            valid    <= 1'b1;
            pwm_val  <= {dir_dly, 7'd0};
            per_cnt  <= 16'd1;
            high_cnt <= 16'd0;
          end else begin
            per_cnt <= per_inc;
          end
        end
        default: begin
          state <= SYNC;
        end
      endcase
    end
  end

endmodule
